readout_sink: RTL

- Receiving end of the readout address stream: consumes the `running`/`addr` beats produced by the address generator, together with the memory data returned for each address.
- Writes each word into an internal buffer, checks that addresses arrive in contiguous 0..DEPTH-1 order, and accumulates word count and checksum.
- Signals frame completion so downstream logic can read the buffer back through a registered read port.

---
 rtl/readout_pkg.sv | 14 +
 rtl/readout_buf.sv | 34 +++
 rtl/readout_sink.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared types and widths for the readout address/data path.
// Defaults match the address generator so both ends agree on frame geometry.
package readout_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int CHECKSUM_W = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

endpackage

// File: rtl/readout_buf.sv
// Frame buffer: one write port, registered read port (1 cycle), old data on collision.
// No backpressure: a write is accepted every cycle we is high.
module readout_buf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read sees the array before this edge's write lands, giving old data on collision.
  always_comb rd_data_d = mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/readout_sink.sv
// Captures a 0..DEPTH-1 readout frame into a buffer, checking order and summing words.
// Frame status registered one cycle after the closing beat; no backpressure, every beat accepted.
module readout_sink
  import readout_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  running,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       count,
  output logic [CHECKSUM_W-1:0] sum,
  output logic                  seq_err,
  output logic                  short_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

  logic              v;
  logic [ADDR_W-1:0] a;

  if (RD_LAT == 0) begin : g_nodly
    assign v = running;
    assign a = addr;
  end else begin : g_dly
    logic [RD_LAT-1:0]             run_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] adr_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        run_q <= '0;
        adr_q <= '0;
      end else begin
        run_q[0] <= running;
        adr_q[0] <= addr;
        for (int i = 1; i < RD_LAT; i++) begin
          run_q[i] <= run_q[i-1];
          adr_q[i] <= adr_q[i-1];
        end
      end
    end

    assign v = run_q[RD_LAT-1];
    assign a = adr_q[RD_LAT-1];
  end

  readout_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (v),
    .wr_addr (a),
    .wr_data (data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  state_e                state_q, state_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic [CHECKSUM_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]     exp_q, exp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [CHECKSUM_W-1:0] sum_q, sum_d;
  logic                  seq_err_q, seq_err_d;
  logic                  short_err_q, short_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    exp_d       = exp_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    count_d     = count_q;
    sum_d       = sum_q;
    seq_err_d   = seq_err_q;
    short_err_d = short_err_q;

    unique case (state_q)
      IDLE: begin
        if (v && a == '0) begin
          state_d     = CAPTURE;
          busy_d      = 1'b1;
          cnt_d       = (ADDR_W+1)'(1);
          acc_d       = CHECKSUM_W'(data);
          exp_d       = ADDR_W'(1);
          seq_err_d   = 1'b0;
          short_err_d = 1'b0;
        end else if (v) begin
          seq_err_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (!v || (a == '0 && exp_q == '0)) begin
          done_d      = 1'b1;
          count_d     = cnt_q;
          sum_d       = acc_q;
          short_err_d = (cnt_q < DEPTH_C);
        end
        if (!v) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (a == '0 && exp_q == '0) begin
          // Wrap straight into the next frame; this beat is its first word.
          cnt_d     = (ADDR_W+1)'(1);
          acc_d     = CHECKSUM_W'(data);
          exp_d     = ADDR_W'(1);
          seq_err_d = 1'b0;
        end else begin
          cnt_d = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + (ADDR_W+1)'(1);
          acc_d = acc_q + CHECKSUM_W'(data);
          exp_d = a + ADDR_W'(1);
          if (a != exp_q) seq_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      exp_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      seq_err_q   <= 1'b0;
      short_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      exp_q       <= exp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      seq_err_q   <= seq_err_d;
      short_err_q <= short_err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign sum       = sum_q;
  assign seq_err   = seq_err_q;
  assign short_err = short_err_q;

endmodule
